// File: rtl/renas_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : renas_apb_pkg
// Purpose  : Shared types and constants for the renas AHB-lite to APB4
//            bridge: bridge FSM state encoding, AHB transfer-type, size and
//            response codes, and the APB4 byte-strobe helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package renas_apb_pkg;

  // Bridge FSM states. The 3-bit width is explicit so the encoding is stable
  // across tools.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    DONE   = 3'd3,
    ERR1   = 3'd4,
    ERR2   = 3'd5
  } apb_state_e;

  // AHB transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // AHB transfer sizes supported by a 32-bit bus
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // AHB responses
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Byte lanes touched by a transfer of the given size at the given low
  // address bits. Callers only use this for transfers already known to be
  // naturally aligned.
  function automatic logic [3:0] byte_strobe(input logic [2:0] size,
                                             input logic [1:0] lsb);
    logic [3:0] strb;
    case (size)
      HSIZE_BYTE: strb = 4'b0001 << lsb;
      HSIZE_HALF: strb = 4'b0011 << lsb;
      default:    strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/renas_apb_decoder.sv
`default_nettype none
// ============================================================================
// Module   : renas_apb_decoder
// Purpose  : Combinational address-phase decode for the AHB to APB bridge:
//            peripheral index range check, size/alignment legality, one-hot
//            peripheral select and APB4 write strobes.
// Ports    : sel_field  - haddr peripheral index field
//            addr_lsb   - haddr[1:0]
//            hsize      - AHB transfer size
//            hwrite     - AHB direction (1 = write)
//            legal      - transfer may be forwarded to APB
//            psel_1h    - one-hot select for the indexed peripheral
//            pstrb      - byte strobes (all zero for reads)
// Revision : 1.0 - initial release
// ============================================================================
module renas_apb_decoder
  import renas_apb_pkg::*;
#(
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_W   = 4
) (
  input  logic [SEL_W-1:0]   sel_field,
  input  logic [1:0]         addr_lsb,
  input  logic [2:0]         hsize,
  input  logic               hwrite,
  output logic               legal,
  output logic [NUM_SLV-1:0] psel_1h,
  output logic [3:0]         pstrb
);

  logic w_idx_ok;
  logic w_align_ok;

  assign w_idx_ok = (32'(sel_field) < NUM_SLV);

  // Sizes above a word cannot be carried by a 32-bit APB bus.
  always_comb begin
    w_align_ok = 1'b0;
    case (hsize)
      HSIZE_BYTE: w_align_ok = 1'b1;
      HSIZE_HALF: w_align_ok = ~addr_lsb[0];
      HSIZE_WORD: w_align_ok = (addr_lsb == 2'b00);
      default:    w_align_ok = 1'b0;
    endcase
  end

  assign legal = w_idx_ok & w_align_ok;

  // Compare at 32 bits so an index field narrower than the slave count can
  // never alias onto two select lines.
  for (genvar i = 0; i < int'(NUM_SLV); i++) begin : g_psel
    assign psel_1h[i] = w_idx_ok & (32'(sel_field) == 32'(i));
  end

  assign pstrb = hwrite ? byte_strobe(hsize, addr_lsb) : 4'b0000;

endmodule
`default_nettype wire

// File: rtl/renas_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : renas_ahb2apb_bridge
// Purpose  : AHB-lite slave that converts each accepted transfer into a single
//            APB4 transaction on one of NUM_SLV peripheral selects. One
//            transfer outstanding at a time, no write posting. Illegal
//            transfers and APB errors/timeouts give a two-cycle AHB ERROR.
// Ports    : hclk, hreset            - clock, async active-high reset
//            hsel/haddr/htrans/hwrite/hsize/hready - AHB address phase
//            hwdata                  - AHB write data (data phase)
//            hreadyout/hresp/hrdata  - AHB response
//            paddr/psel/penable/pwrite/pwdata/pstrb - APB4 requester
//            prdata/pready/pslverr   - per-peripheral APB4 completer returns
// Revision : 1.0 - initial release
// ============================================================================
module renas_ahb2apb_bridge
  import renas_apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SEL_LSB = 12,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic                      hsel,
  input  logic [ADDR_W-1:0]         haddr,
  input  logic [1:0]                htrans,
  input  logic                      hwrite,
  input  logic [2:0]                hsize,
  input  logic                      hready,
  input  logic [DATA_W-1:0]         hwdata,
  output logic                      hreadyout,
  output logic                      hresp,
  output logic [DATA_W-1:0]         hrdata,
  output logic [ADDR_W-1:0]         paddr,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [DATA_W-1:0]         pwdata,
  output logic [3:0]                pstrb,
  input  logic [NUM_SLV*DATA_W-1:0] prdata,
  input  logic [NUM_SLV-1:0]        pready,
  input  logic [NUM_SLV-1:0]        pslverr
);

  localparam int unsigned    CNT_W          = 16;
  localparam logic [CNT_W-1:0] c_TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e           r_state;
  apb_state_e           w_state_nxt;

  logic [ADDR_W-1:0]    r_paddr;
  logic [NUM_SLV-1:0]   r_psel;
  logic                 r_penable;
  logic                 r_pwrite;
  logic [DATA_W-1:0]    r_pwdata;
  logic [3:0]           r_pstrb;
  logic [DATA_W-1:0]    r_hrdata;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_active;
  logic                 w_accept;
  logic                 w_legal;
  logic [NUM_SLV-1:0]   w_psel_1h;
  logic [3:0]           w_pstrb;
  logic                 w_sel_ready;
  logic                 w_sel_err;
  logic                 w_timeout;
  logic [DATA_W-1:0]    w_sel_rdata;

  // --------------------------------------------------------------------------
  // Address-phase decode
  // --------------------------------------------------------------------------
  renas_apb_decoder #(
    .NUM_SLV (NUM_SLV),
    .SEL_W   (SEL_W)
  ) u_decoder (
    .sel_field (haddr[SEL_LSB +: SEL_W]),
    .addr_lsb  (haddr[1:0]),
    .hsize     (hsize),
    .hwrite    (hwrite),
    .legal     (w_legal),
    .psel_1h   (w_psel_1h),
    .pstrb     (w_pstrb)
  );

  assign w_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  // hreadyout is high in exactly IDLE and DONE among the accepting states;
  // ERR2 also drives it high but deliberately refuses new transfers, so the
  // qualifier is expressed on state rather than on hreadyout itself.
  assign w_accept = hsel & hready & w_active &
                    ((r_state == IDLE) || (r_state == DONE));

  // Only the selected peripheral's handshake and data are observed.
  assign w_sel_ready = |(pready  & r_psel);
  assign w_sel_err   = |(pslverr & r_psel);
  assign w_timeout   = (r_cnt == c_TIMEOUT_LAST);

  always_comb begin
    w_sel_rdata = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (r_psel[i]) begin
        w_sel_rdata = w_sel_rdata | prdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and AHB response
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    hreadyout   = 1'b1;
    hresp       = HRESP_OKAY;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) begin
          w_state_nxt = w_legal ? SETUP : ERR1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETUP: begin
        hreadyout   = 1'b0;
        w_state_nxt = ACCESS;
      end
      ACCESS: begin
        hreadyout = 1'b0;
        if (w_sel_ready) begin
          w_state_nxt = w_sel_err ? ERR1 : DONE;
        end else if (w_timeout) begin
          w_state_nxt = ERR1;
        end
      end
      ERR1: begin
        hreadyout   = 1'b0;
        hresp       = HRESP_ERROR;
        w_state_nxt = ERR2;
      end
      ERR2: begin
        hresp       = HRESP_ERROR;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // APB request, read data and timeout counter
  // --------------------------------------------------------------------------
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_paddr   <= '0;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= 4'b0000;
      r_hrdata  <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // Illegal transfers leave the APB side untouched.
          if (w_accept && w_legal) begin
            r_paddr  <= haddr;
            r_pwrite <= hwrite;
            r_pstrb  <= w_pstrb;
            r_psel   <= w_psel_1h;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_pwdata  <= hwdata;
          r_cnt     <= '0;
        end
        ACCESS: begin
          if (w_sel_ready) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
            if (!w_sel_err && !r_pwrite) begin
              r_hrdata <= w_sel_rdata;
            end
          end else if (w_timeout) begin
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // hwdata only becomes valid in the AHB data phase, which coincides with
  // SETUP, so pwdata passes it straight through there and is held from the
  // registered copy afterwards.
  assign pwdata  = (r_state == SETUP) ? hwdata : r_pwdata;
  assign paddr   = r_paddr;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign pstrb   = r_pstrb;
  assign hrdata  = r_hrdata;

endmodule
`default_nettype wire

// File: tb/tb_renas_ahb2apb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_renas_ahb2apb_bridge
// Purpose  : Directed, scoreboard-checked bench for renas_ahb2apb_bridge.
//            Stimulus pushes the expected AHB response and APB request into
//            queues; independent monitors pop and compare as the bridge
//            presents them. Peripheral model drives junk on every
//            non-selected slave.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_renas_ahb2apb_bridge;
  import renas_apb_pkg::*;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          lat;
  } ahb_exp_t;

  typedef struct {
    logic [3:0]  psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    int          acc;     // expected ACCESS cycles, 0 = not checked
  } apb_exp_t;

  logic         hclk = 1'b0;
  logic         hreset;
  logic         hsel;
  logic [31:0]  haddr;
  logic [1:0]   htrans;
  logic         hwrite;
  logic [2:0]   hsize;
  logic         hready;
  logic [31:0]  hwdata;
  logic         hreadyout;
  logic         hresp;
  logic [31:0]  hrdata;
  logic [31:0]  paddr;
  logic [3:0]   psel;
  logic         penable;
  logic         pwrite;
  logic [31:0]  pwdata;
  logic [3:0]   pstrb;
  logic [127:0] prdata  = '0;
  logic [3:0]   pready  = 4'b1111;
  logic [3:0]   pslverr = 4'b1111;

  always #5 hclk = ~hclk;

  renas_ahb2apb_bridge #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NUM_SLV (4),
    .SEL_LSB (12),
    .SEL_W   (4),
    .TIMEOUT (8)
  ) dut (
    .hclk      (hclk),
    .hreset    (hreset),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hready    (hready),
    .hwdata    (hwdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .paddr     (paddr),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .pwdata    (pwdata),
    .pstrb     (pstrb),
    .prdata    (prdata),
    .pready    (pready),
    .pslverr   (pslverr)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  ahb_exp_t ahb_q[$];
  apb_exp_t apb_q[$];
  int n_vec = 0;
  int n_err = 0;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void push_ahb(input logic resp, input logic [31:0] rdata,
                                   input int lat);
    ahb_exp_t e;
    e.resp = resp; e.rdata = rdata; e.lat = lat;
    ahb_q.push_back(e);
  endfunction

  function automatic void push_apb(input logic [3:0] ps, input logic [31:0] pa,
                                   input logic pw, input logic [3:0] st,
                                   input logic [31:0] wd, input int acc);
    apb_exp_t e;
    e.psel = ps; e.paddr = pa; e.pwrite = pw; e.pstrb = st; e.pwdata = wd; e.acc = acc;
    apb_q.push_back(e);
  endfunction

  // --------------------------------------------------------------------------
  // Peripheral model
  // --------------------------------------------------------------------------
  int          wait_cfg[4];
  bit          err_cfg[4];
  bit          never_cfg[4];
  logic [31:0] rd_cfg[4];
  int          acc_cnt = 0;

  always @(posedge hclk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (psel[i] && penable) begin
        pready[i]          = !never_cfg[i] && (acc_cnt >= wait_cfg[i]);
        pslverr[i]         = err_cfg[i];
        prdata[i*32 +: 32] = rd_cfg[i];
      end else begin
        pready[i]          = 1'b1;
        pslverr[i]         = 1'b1;
        prdata[i*32 +: 32] = 32'hBAD0_0000 | 32'(i);
      end
    end
    if (penable) acc_cnt++;
    else         acc_cnt = 0;
  end

  // --------------------------------------------------------------------------
  // AHB response monitor
  // --------------------------------------------------------------------------
  int       cyc = 0;
  int       acc_cyc = 0;
  bit       pend = 1'b0;
  logic     prev_rdy = 1'b1;
  logic     prev_resp = 1'b0;
  ahb_exp_t ahb_e;

  always @(negedge hclk) begin
    if (hreset) begin
      pend      = 1'b0;
      prev_rdy  = 1'b1;
      prev_resp = 1'b0;
    end else begin
      cyc++;
      if (pend && hreadyout) begin
        pend = 1'b0;
        if (ahb_q.size() == 0) begin
          check("ahb_unexpected_resp", 32'(hreadyout), 32'(0));
        end else begin
          ahb_e = ahb_q.pop_front();
          check("hresp", 32'(hresp), 32'(ahb_e.resp));
          check("hrdata", hrdata, ahb_e.rdata);
          check("latency", 32'(cyc - acc_cyc), 32'(ahb_e.lat));
          if (ahb_e.resp) check("err_first_cycle", 32'({prev_rdy, prev_resp}), 32'(2'b01));
        end
      end
      if (hsel && hready && htrans[1] && hreadyout) begin
        pend    = 1'b1;
        acc_cyc = cyc;
      end
      prev_rdy  = hreadyout;
      prev_resp = hresp;
    end
  end

  // --------------------------------------------------------------------------
  // APB request monitor
  // --------------------------------------------------------------------------
  apb_exp_t cur;
  bit       in_acc = 1'b0;
  int       acnt = 0;
  int       cyc2 = 0;
  int       last_acc = 0;

  always @(negedge hclk) begin
    if (hreset) begin
      in_acc = 1'b0;
    end else begin
      cyc2++;
      if (psel != 4'b0000 && !penable) begin
        if (apb_q.size() == 0) begin
          check("apb_unexpected_setup", 32'(psel), 32'(0));
        end else begin
          cur = apb_q.pop_front();
          check("psel", 32'(psel), 32'(cur.psel));
          check("paddr", paddr, cur.paddr);
          check("pwrite", 32'(pwrite), 32'(cur.pwrite));
          check("pstrb", 32'(pstrb), 32'(cur.pstrb));
          if (cur.pwrite) check("pwdata", pwdata, cur.pwdata);
          check("setup_after_accept", 32'(cyc2 - last_acc), 32'(1));
          in_acc = 1'b1;
          acnt   = 0;
        end
      end else if (psel != 4'b0000 && penable) begin
        acnt++;
        if (in_acc) begin
          check("access_paddr_stable", paddr, cur.paddr);
          if (cur.pwrite) check("access_pwdata_stable", pwdata, cur.pwdata);
        end
      end else if (in_acc) begin
        in_acc = 1'b0;
        if (cur.acc != 0) check("access_cycles", 32'(acnt), 32'(cur.acc));
      end
      if (hsel && hready && htrans[1] && hreadyout) last_acc = cyc2;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  // Entered just after a rising edge. Presents the address phase, holds it
  // until the bridge is ready, then drives the data phase.
  task automatic xfer(input logic [31:0] a, input logic wr, input logic [2:0] sz,
                      input logic [31:0] wd, input bit last);
    logic r;
    int   g;
    hsel   = 1'b1;
    haddr  = a;
    htrans = HTRANS_NONSEQ;
    hwrite = wr;
    hsize  = sz;
    g      = 0;
    do begin
      @(negedge hclk); r = hreadyout;
      @(posedge hclk); #1;
      g++;
    end while (!r && g < 100);
    check("accept_seen", 32'(r), 32'(1));
    hwdata = wd;
    if (last) begin
      hsel   = 1'b0;
      htrans = HTRANS_IDLE;
    end
  endtask

  task automatic wait_idle();
    logic r;
    int   g;
    g = 0;
    do begin
      @(negedge hclk); r = hreadyout;
      @(posedge hclk); #1;
      g++;
    end while (!r && g < 100);
    check("response_seen", 32'(r), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion, expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    hreset = 1'b1;
    hsel   = 1'b0;
    haddr  = '0;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
    hsize  = HSIZE_BYTE;
    hready = 1'b1;
    hwdata = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0; err_cfg[i] = 1'b0; never_cfg[i] = 1'b0; rd_cfg[i] = 32'h0;
    end

    repeat (3) @(posedge hclk);
    #1;
    check("rst_hreadyout", 32'(hreadyout), 32'(1));
    check("rst_hresp",     32'(hresp),     32'(0));
    check("rst_hrdata",    hrdata,         32'h0);
    check("rst_psel",      32'(psel),      32'(0));
    check("rst_penable",   32'(penable),   32'(0));
    check("rst_pwrite",    32'(pwrite),    32'(0));
    check("rst_paddr",     paddr,          32'h0);
    check("rst_pwdata",    pwdata,         32'h0);
    check("rst_pstrb",     32'(pstrb),     32'(0));
    hreset = 1'b0;
    @(posedge hclk); #1;

    // Zero-wait word write to slave 1
    push_apb(4'b0010, 32'h1000_1004, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1);
    push_ahb(HRESP_OKAY, 32'h0, 3);
    xfer(32'h1000_1004, 1'b1, HSIZE_WORD, 32'hDEAD_BEEF, 1'b1);
    wait_idle();

    // Halfword read from slave 2 with three wait states
    wait_cfg[2] = 3; rd_cfg[2] = 32'h1234_5678;
    push_apb(4'b0100, 32'h1000_2002, 1'b0, 4'b0000, 32'h0, 4);
    push_ahb(HRESP_OKAY, 32'h1234_5678, 6);
    xfer(32'h1000_2002, 1'b0, HSIZE_HALF, 32'h0, 1'b1);
    wait_idle();
    wait_cfg[2] = 0;

    // Byte write to lane 3 of slave 0, peripheral reports an error
    err_cfg[0] = 1'b1;
    push_apb(4'b0001, 32'h1000_0003, 1'b1, 4'b1000, 32'hAA00_0000, 1);
    push_ahb(HRESP_ERROR, 32'h1234_5678, 4);
    xfer(32'h1000_0003, 1'b1, HSIZE_BYTE, 32'hAA00_0000, 1'b1);
    wait_idle();
    err_cfg[0] = 1'b0;

    // Illegal transfers: index out of range, misaligned word, odd halfword,
    // oversize. None may reach APB.
    push_ahb(HRESP_ERROR, 32'h1234_5678, 2);
    xfer(32'h1000_7000, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
    wait_idle();
    push_ahb(HRESP_ERROR, 32'h1234_5678, 2);
    xfer(32'h1000_0002, 1'b1, HSIZE_WORD, 32'h5555_AAAA, 1'b1);
    wait_idle();
    push_ahb(HRESP_ERROR, 32'h1234_5678, 2);
    xfer(32'h1000_1001, 1'b0, HSIZE_HALF, 32'h0, 1'b1);
    wait_idle();
    push_ahb(HRESP_ERROR, 32'h1234_5678, 2);
    xfer(32'h1000_0000, 1'b0, 3'b011, 32'h0, 1'b1);
    wait_idle();

    // Slave 3 never answers: abort after 8 ACCESS cycles
    never_cfg[3] = 1'b1;
    push_apb(4'b1000, 32'h1000_3000, 1'b0, 4'b0000, 32'h0, 8);
    push_ahb(HRESP_ERROR, 32'h1234_5678, 11);
    xfer(32'h1000_3000, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
    wait_idle();
    check("timeout_psel_cleared", 32'(psel), 32'(0));

    // Back-to-back write then read, second accepted in the DONE cycle
    never_cfg[3] = 1'b0;
    rd_cfg[2] = 32'h5A5A_0F0F;
    push_apb(4'b0010, 32'h1000_1008, 1'b1, 4'b1111, 32'hCAFE_F00D, 1);
    push_ahb(HRESP_OKAY, 32'h1234_5678, 3);
    push_apb(4'b0100, 32'h1000_2000, 1'b0, 4'b0000, 32'h0, 1);
    push_ahb(HRESP_OKAY, 32'h5A5A_0F0F, 3);
    xfer(32'h1000_1008, 1'b1, HSIZE_WORD, 32'hCAFE_F00D, 1'b0);
    xfer(32'h1000_2000, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
    wait_idle();

    // Reset while a transfer sits in ACCESS: response is abandoned
    never_cfg[3] = 1'b1;
    push_apb(4'b1000, 32'h1000_3004, 1'b0, 4'b0000, 32'h0, 0);
    xfer(32'h1000_3004, 1'b0, HSIZE_WORD, 32'h0, 1'b1);
    g = 0;
    while (!penable && g < 20) begin
      @(posedge hclk); #1;
      g++;
    end
    check("reached_access", 32'(penable), 32'(1));
    #2 hreset = 1'b1;
    #1;
    check("mid_rst_psel",      32'(psel),      32'(0));
    check("mid_rst_penable",   32'(penable),   32'(0));
    check("mid_rst_hreadyout", 32'(hreadyout), 32'(1));
    check("mid_rst_hresp",     32'(hresp),     32'(0));
    check("mid_rst_hrdata",    hrdata,         32'h0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    never_cfg[3] = 1'b0;
    @(posedge hclk); #1;

    // Recovery after reset
    push_apb(4'b0001, 32'h1000_0000, 1'b1, 4'b1111, 32'h1122_3344, 1);
    push_ahb(HRESP_OKAY, 32'h0, 3);
    xfer(32'h1000_0000, 1'b1, HSIZE_WORD, 32'h1122_3344, 1'b1);
    wait_idle();

    repeat (3) @(posedge hclk);
    #1;
    check("ahb_queue_drained", 32'(ahb_q.size()), 32'(0));
    check("apb_queue_drained", 32'(apb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
